// File: rtl/lcd_screen_arbiter_if.sv
// lcd_screen_arbiter_if
//   Bus bundle between the message sources and the screen arbiter.
//   master : source side. It drives the background lines, the pop-up requests
//            and content, and cancel. It reads back the line buffers, active_src
//            and the done pulses.
//   slave  : arbiter side. The directions are the reverse of master.
//   Each line is 128 bits wide. Character 0 sits in bits [127:120].
interface lcd_screen_arbiter_if;
  logic [127:0] bg_line1;
  logic [127:0] bg_line2;
  logic         pop1_req;
  logic [127:0] pop1_line1;
  logic [127:0] pop1_line2;
  logic         pop2_req;
  logic [127:0] pop2_line1;
  logic [127:0] pop2_line2;
  logic         cancel;
  logic [127:0] line1_buffer;
  logic [127:0] line2_buffer;
  logic [1:0]   active_src;
  logic         pop1_done;
  logic         pop2_done;

  modport master (
    output bg_line1, bg_line2, pop1_req, pop1_line1, pop1_line2,
           pop2_req, pop2_line1, pop2_line2, cancel,
    input  line1_buffer, line2_buffer, active_src, pop1_done, pop2_done
  );

  modport slave (
    input  bg_line1, bg_line2, pop1_req, pop1_line1, pop1_line2,
           pop2_req, pop2_line1, pop2_line2, cancel,
    output line1_buffer, line2_buffer, active_src, pop1_done, pop2_done
  );
endinterface

// File: rtl/lcd_screen_arbiter.sv
// lcd_screen_arbiter
//   Shares one 2x16 text LCD between three sources:
//     - source 0: the live background screen
//     - source 1: a one-shot pop-up
//     - source 2: a one-shot pop-up with higher priority than source 1
//   A pop-up's content is snapshotted on its request pulse. The pop-up is then
//   shown for DISPLAY_CYCLES clocks. After that the display falls back to the
//   next pending pop-up, or to the background if none is pending.
// Ports
//   clk, rst_n : system clock and asynchronous active-low reset
//   bus        : lcd_screen_arbiter_if.slave
//                inputs : bg_line1/2, popN_req, popN_line1/2, cancel
//                outputs: line1/2_buffer (registered), active_src, popN_done
module lcd_screen_arbiter #(
  parameter int unsigned DISPLAY_CYCLES = 50000000,
  parameter logic [7:0]  BLANK_CHAR     = 8'h20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lcd_screen_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    S_BG   = 2'd0,
    S_POP1 = 2'd1,
    S_POP2 = 2'd2
  } state_t;

  typedef struct packed {
    logic [127:0] line1;
    logic [127:0] line2;
  } screen_t;

  localparam logic [31:0] LAST_TICK    = 32'(DISPLAY_CYCLES - 1);
  localparam screen_t     BLANK_SCREEN = {32{BLANK_CHAR}};

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        pend1_q, pend1_d;
  logic        pend2_q, pend2_d;
  screen_t     slot1_q, slot1_d;
  screen_t     slot2_q, slot2_d;
  screen_t     disp_q,  disp_d;
  logic        done1_q, done1_d;
  logic        done2_q, done2_d;
  logic        retrig;

  // A request for the pop-up already on screen restarts its period.
  assign retrig = (state_q == S_POP1 && bus.pop1_req) ||
                  (state_q == S_POP2 && bus.pop2_req);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend1_d = pend1_q;
    pend2_d = pend2_q;
    slot1_d = slot1_q;
    slot2_d = slot2_q;
    done1_d = 1'b0;
    done2_d = 1'b0;

    if (bus.cancel) begin
      // Cancel wins over everything, including same-cycle requests.
      state_d = S_BG;
      pend1_d = 1'b0;
      pend2_d = 1'b0;
      timer_d = '0;
    end else begin
      if (bus.pop1_req) begin
        slot1_d = {bus.pop1_line1, bus.pop1_line2};
        pend1_d = 1'b1;
      end
      if (bus.pop2_req) begin
        slot2_d = {bus.pop2_line1, bus.pop2_line2};
        pend2_d = 1'b1;
      end

      if ((pend2_q || bus.pop2_req) && state_q != S_POP2) begin
        // Preemption. If source 1 was on screen, pend1 stays set, so source 1
        // comes back later with a fresh full period.
        state_d = S_POP2;
        timer_d = '0;
      end else if (retrig) begin
        timer_d = '0;
      end else if (state_q != S_BG && timer_q == LAST_TICK) begin
        if (state_q == S_POP1) begin
          done1_d = 1'b1;
          pend1_d = 1'b0;
        end else begin
          done2_d = 1'b1;
          pend2_d = 1'b0;
        end
        // The pending flags below already include this cycle's clear and any
        // request captured in this cycle.
        if (pend2_d)      state_d = S_POP2;
        else if (pend1_d) state_d = S_POP1;
        else              state_d = S_BG;
        timer_d = '0;
      end else if (state_q == S_BG && (pend1_q || bus.pop1_req)) begin
        state_d = S_POP1;
        timer_d = '0;
      end else if (state_q != S_BG) begin
        timer_d = timer_q + 32'd1;
      end
    end

    // The line buffers follow the current state. The background is tracked live.
    case (state_q)
      S_POP1:  disp_d = slot1_q;
      S_POP2:  disp_d = slot2_q;
      default: disp_d = {bus.bg_line1, bus.bg_line2};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BG;
      timer_q <= '0;
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
      slot1_q <= '0;
      slot2_q <= '0;
      disp_q  <= BLANK_SCREEN;
      done1_q <= 1'b0;
      done2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      slot1_q <= slot1_d;
      slot2_q <= slot2_d;
      disp_q  <= disp_d;
      done1_q <= done1_d;
      done2_q <= done2_d;
    end
  end

  assign bus.line1_buffer = disp_q.line1;
  assign bus.line2_buffer = disp_q.line2;
  assign bus.active_src   = state_q;
  assign bus.pop1_done    = done1_q;
  assign bus.pop2_done    = done2_q;
endmodule
